mdu: RTL



---
 rtl/cpu54_defs.sv | 32 +++
 rtl/mdu_sign_fix.sv | 31 +++
 rtl/mdu.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/cpu54_defs.sv
// Shared definitions for the cpu54 datapath: MDU op codes, operand width
// and the multiply/divide FSM state encoding.
package cpu54_defs;

  localparam int MDU_WIDTH = 32;

  localparam logic [2:0] MDU_MULT  = 3'b000;
  localparam logic [2:0] MDU_MULTU = 3'b001;
  localparam logic [2:0] MDU_DIV   = 3'b010;
  localparam logic [2:0] MDU_DIVU  = 3'b011;
  localparam logic [2:0] MDU_MTHI  = 3'b100;
  localparam logic [2:0] MDU_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2
  } mdu_state_e;

  function automatic logic mdu_is_arith(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic mdu_is_mult(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic mdu_is_signed(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negation, used both to take operand magnitudes
// on entry and to restore result signs on exit.
module mdu_sign_fix
  import cpu54_defs::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic [WIDTH-1:0] x_hi,
  input  logic [WIDTH-1:0] x_lo,
  input  logic             neg_hi,
  input  logic             neg_lo,
  input  logic             joint,
  output logic [WIDTH-1:0] y_hi,
  output logic [WIDTH-1:0] y_lo
);

  logic [2*WIDTH-1:0] pair;
  logic [2*WIDTH-1:0] pair_neg;

  // joint treats hi:lo as one 64-bit product; otherwise each half is independent
  always_comb begin
    pair     = {x_hi, x_lo};
    pair_neg = -pair;
    y_hi     = neg_hi ? -x_hi : x_hi;
    y_lo     = neg_lo ? -x_lo : x_lo;
    if (joint) begin
      {y_hi, y_lo} = neg_hi ? pair_neg : pair;
    end
  end

endmodule

// File: rtl/mdu.sv
// Iterative multiply/divide unit: 32-cycle shift-add multiply and restoring
// divide over a shared 64-bit register, plus the architectural HI/LO pair.
module mdu
  import cpu54_defs::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_e state, state_nxt;

  logic [2:0]         op_q;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [5:0]         cnt;

  logic [WIDTH-1:0]   fix_x_hi, fix_x_lo, fix_y_hi, fix_y_lo;
  logic               fix_neg_hi, fix_neg_lo, fix_joint;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [WIDTH:0]     div_rem;
  logic [WIDTH-1:0]   div_sub;
  logic               div_ok;
  logic [2*WIDTH-1:0] div_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= MDU_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MDU_IDLE: if (start && mdu_is_arith(op)) state_nxt = MDU_CALC;
      MDU_CALC: if (cnt == 6'(WIDTH-1)) state_nxt = MDU_FIX;
      MDU_FIX:  state_nxt = MDU_IDLE;
      default:  state_nxt = MDU_IDLE;
    endcase
  end

  // one sign-fix instance: raw operands while idle, the finished pair in FIX
  always_comb begin
    fix_x_hi   = a;
    fix_x_lo   = b;
    fix_neg_hi = mdu_is_signed(op) & a[WIDTH-1];
    fix_neg_lo = mdu_is_signed(op) & b[WIDTH-1];
    fix_joint  = 1'b0;
    if (state == MDU_FIX) begin
      fix_x_hi = acc[2*WIDTH-1:WIDTH];
      fix_x_lo = acc[WIDTH-1:0];
      if (mdu_is_mult(op_q)) begin
        fix_joint  = 1'b1;
        fix_neg_hi = mdu_is_signed(op_q) & (sign_a ^ sign_b);
        fix_neg_lo = fix_neg_hi;
      end else begin
        fix_neg_hi = mdu_is_signed(op_q) & sign_a;
        fix_neg_lo = mdu_is_signed(op_q) & (sign_a ^ sign_b);
      end
    end
  end

  mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .x_hi   (fix_x_hi),
    .x_lo   (fix_x_lo),
    .neg_hi (fix_neg_hi),
    .neg_lo (fix_neg_lo),
    .joint  (fix_joint),
    .y_hi   (fix_y_hi),
    .y_lo   (fix_y_lo)
  );

  // multiply keeps the multiplier in acc low half; divide keeps the quotient there
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    mul_nxt = acc[0] ? {mul_sum, acc[WIDTH-1:1]}
                     : {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:1]};
    div_rem = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ok  = div_rem >= {1'b0, opnd};
    div_sub = div_rem[WIDTH-1:0] - opnd;
    div_nxt = {div_ok ? div_sub : div_rem[WIDTH-1:0], acc[WIDTH-2:0], div_ok};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        MDU_IDLE: begin
          if (start) begin
            if (mdu_is_arith(op)) begin
              op_q   <= op;
              sign_a <= mdu_is_signed(op) & a[WIDTH-1];
              sign_b <= mdu_is_signed(op) & b[WIDTH-1];
              cnt    <= '0;
              busy   <= 1'b1;
              if (mdu_is_mult(op)) begin
                opnd <= fix_y_hi;
                acc  <= {{WIDTH{1'b0}}, fix_y_lo};
              end else begin
                opnd <= fix_y_lo;
                acc  <= {{WIDTH{1'b0}}, fix_y_hi};
              end
            end else if (op == MDU_MTHI) begin
              hi <= a;
            end else if (op == MDU_MTLO) begin
              lo <= a;
            end
          end
        end
        MDU_CALC: begin
          acc <= mdu_is_mult(op_q) ? mul_nxt : div_nxt;
          cnt <= cnt + 6'd1;
        end
        MDU_FIX: begin
          hi   <= fix_y_hi;
          lo   <= fix_y_lo;
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
